// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32-entry register file: clears X0..X30 after reset,
// then round-robin arbitrates ALU and memory writebacks onto the single write port.
//
// state | meaning
// INIT  | issuing zero writes to X0..X30, one per cycle; both readys held low
// RUN   | arbitrating ALU (A) and memory (M) writeback requests
module regfile_wb_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         a_valid,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         m_valid,
  input  logic [4:0]   m_addr,
  input  logic [N-1:0] m_data,
  output logic         m_ready,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         init_done
);

  localparam logic S_INIT = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_M = 1'b1;

  logic       state;
  logic [4:0] cnt;
  logic       last;
  logic       grant_a;
  logic       grant_m;

  // On a tie the requester that was not served most recently wins.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (state == S_RUN) begin
      if (a_valid && m_valid) begin
        if (last == SRC_A) grant_m = 1'b1;
        else               grant_a = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_m = m_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      cnt       <= 5'd0;
      last      <= SRC_A;
      we3       <= 1'b0;
      wa3       <= 5'd0;
      wd3       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          we3 <= 1'b1;
          wa3 <= cnt;
          wd3 <= '0;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd30) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          // X31 requests still handshake but never reach the register file.
          if (grant_a) begin
            we3  <= ~&a_addr;
            wa3  <= a_addr;
            wd3  <= a_data;
            last <= SRC_A;
          end else if (grant_m) begin
            we3  <= ~&m_addr;
            wa3  <= m_addr;
            wd3  <= m_data;
            last <= SRC_M;
          end else begin
            we3 <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
